// File: rtl/fetch_queue_pkg.sv
// Shared fetch types: PC/instruction widths, branch opcodes, FIFO entry.
// FETCH_PREDECODE_EN adds a per-entry is_branch bit.
package upower_pkg;

  localparam int XLEN_PC = 32;
  localparam int INSTR_W = 32;

  localparam logic [5:0] OP_B  = 6'd18;
  localparam logic [5:0] OP_BC = 6'd19;

  typedef struct packed {
    logic [XLEN_PC-1:0] pc;
    logic [INSTR_W-1:0] instr;
`ifdef FETCH_PREDECODE_EN
    logic               is_branch;
`endif
  } fetch_entry_t;

  function automatic logic is_branch_op(
    input logic [INSTR_W-1:0] instr
  );
    return (instr[31:26] == OP_B) ||
           (instr[31:26] == OP_BC);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch bus: imem request/response plus decoded-side show-ahead output.
// master = fetch_queue, slave = memory/consumer (FETCH_PREDECODE_EN adds out_is_branch).
interface fetch_queue_if;
  import upower_pkg::*;

  logic               imem_req;
  logic [XLEN_PC-1:0] imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN_PC-1:0] out_pc;
  logic [INSTR_W-1:0] out_instr;
`ifdef FETCH_PREDECODE_EN
  logic               out_is_branch;
`endif

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_pc,
`ifdef FETCH_PREDECODE_EN
    output out_is_branch,
`endif
    output out_instr
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_pc,
`ifdef FETCH_PREDECODE_EN
    input  out_is_branch,
`endif
    input  out_instr
  );

endinterface

// File: rtl/fetch_queue_fifo.sv
// Show-ahead FIFO of fetch entries with push/pop/flush and occupancy.
// Ports: clock, reset, flush, push, push_data, pop, head, count, full, empty.
module fetch_fifo
  import upower_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign head   = mem[rptr];

  always_ff @(posedge clock) begin
    if (push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case (1'b1)
        push && !do_pop: count <= count + 1'b1;
        do_pop && !push: count <= count - 1'b1;
        default:         count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front-end: owns fetch_pc, issues imem reads, buffers results.
// Ports: clock, reset, redirect_valid/pc, bus (fetch_queue_if.master); macro FETCH_PREDECODE_EN.
module fetch_queue
  import upower_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [XLEN_PC-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN_PC-1:0] redirect_pc,
  fetch_queue_if.master      bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [XLEN_PC-1:0] fetch_pc;
  logic [XLEN_PC-1:0] inflight_pc;
  logic               inflight;
  logic [CW-1:0]      count;
  logic [CW:0]        credit;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               req;
  logic               vld;
  fetch_entry_t       wr;
  fetch_entry_t       head;

  // Credit counts in-flight reads so a response always has a slot,
  // even if nothing pops this cycle.
  assign credit = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign req    = !reset && !redirect_valid &&
                  !full && (credit < LIMIT);
  assign push   = inflight && !redirect_valid && !reset;
  assign vld    = !empty && !reset && !redirect_valid;
  assign pop    = vld && bus.out_ready;

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = vld;

  always_comb begin
    wr       = '0;
    wr.pc    = inflight_pc;
    wr.instr = bus.imem_rdata;
`ifdef FETCH_PREDECODE_EN
    wr.is_branch = is_branch_op(bus.imem_rdata);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= redirect_pc;
      inflight    <= 1'b0;
    end else begin
      inflight <= req;
      if (req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (wr),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Head fields read as zero when nothing is buffered.
  assign bus.out_pc    = (empty || reset) ? '0 : head.pc;
  assign bus.out_instr = (empty || reset) ? '0 : head.instr;
`ifdef FETCH_PREDECODE_EN
  assign bus.out_is_branch =
    (empty || reset) ? 1'b0 : head.is_branch;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue model.
// Summary: CHECKS n ERRORS m.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Model state: architectural queue contents and pending read.
  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];
  logic [31:0] m_fetch;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic        prev_req;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h100) return 32'h4800_0010;
    if (a == 32'h101) return 32'h7C00_0000;
    return 32'h1000_0000 | a;
  endfunction

  function automatic logic pred(input logic [31:0] i);
    logic [5:0] po;
    po = i[31:26];
    return (po == 6'd18) || (po == 6'd19);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic        rst,
                     input logic        rv,
                     input logic [31:0] rpc,
                     input logic        rdy);
    logic e_req;
    logic e_valid;
    int   occ;
    @(negedge clock);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    bus.out_ready  = rdy;
    bus.imem_rdata = prev_req ? mem(prev_addr) : $urandom;
    #1;
    occ     = q_pc.size() + int'(m_infl);
    e_req   = !rst && !rv && (occ < DEPTH);
    e_valid = !rst && !rv && (q_pc.size() != 0);
    chk("imem_req", 32'(bus.imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", bus.imem_addr, m_fetch);
    chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
    if (e_valid) begin
      chk("out_pc", bus.out_pc, q_pc[0]);
      chk("out_instr", bus.out_instr, q_in[0]);
`ifdef FETCH_PREDECODE_EN
      chk("out_is_branch", 32'(bus.out_is_branch),
          32'(pred(q_in[0])));
`endif
    end
    prev_req  = bus.imem_req;
    prev_addr = bus.imem_addr;
    if (rst) begin
      m_fetch = 32'd0;
      m_infl  = 1'b0;
      q_pc.delete();
      q_in.delete();
    end else if (rv) begin
      m_fetch = rpc;
      m_infl  = 1'b0;
      q_pc.delete();
      q_in.delete();
    end else begin
      if (e_valid && rdy) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      if (m_infl) begin
        q_pc.push_back(m_infl_pc);
        q_in.push_back(mem(m_infl_pc));
      end
      if (e_req) begin
        m_infl_pc = m_fetch;
        m_fetch   = m_fetch + 32'd1;
      end
      m_infl = e_req;
    end
  endtask

  initial begin
    logic [31:0] pcs [$];
    logic [31:0] first_req;
    logic        got_req;
    logic        seen;
    int          nreq;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.out_ready  = 1'b0;
    bus.imem_rdata = '0;
    m_fetch        = '0;
    m_infl         = 1'b0;
    m_infl_pc      = '0;
    prev_req       = 1'b0;
    prev_addr      = '0;

    // Reset state and first-fetch latency
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    chk("rst_instr", bus.out_instr, 32'd0);
    cyc(0, 0, 0, 1);
    chk("t1_addr0", bus.imem_addr, 32'd0);
    cyc(0, 0, 0, 1);
    chk("t1_addr1", bus.imem_addr, 32'd1);
    cyc(0, 0, 0, 1);
    chk("t1_addr2", bus.imem_addr, 32'd2);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_pc", bus.out_pc, 32'd0);
    chk("t1_instr", bus.out_instr, 32'h1000_0000);
    cyc(0, 0, 0, 1);
    chk("t1_pc1", bus.out_pc, 32'd1);

    // Backpressure: exactly DEPTH requests, then drain in order
    cyc(1, 0, 0, 0);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (bus.imem_req) nreq++;
    end
    chk("t2_nreq", 32'(nreq), 32'd4);
    chk("t2_hold_pc", bus.out_pc, 32'd0);
    got_req = 1'b0;
    first_req = '1;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1);
      if (bus.out_valid) pcs.push_back(bus.out_pc);
      if (bus.imem_req && !got_req) begin
        got_req   = 1'b1;
        first_req = bus.imem_addr;
      end
    end
    chk("t2_npops", 32'(pcs.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < pcs.size(); i++)
      chk("t2_drain", pcs[i], 32'(i));
    chk("t2_resume", first_req, 32'd4);

    // Redirect with 3 buffered + 1 in flight
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    cyc(0, 1, 32'h40, 1);
    chk("t3_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_req", 32'(bus.imem_req), 32'd0);
    cyc(0, 0, 0, 1);
    chk("t3_addr", bus.imem_addr, 32'h40);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc(0, 0, 0, 1);
      if (bus.out_valid) begin
        seen = 1'b1;
        chk("t3_first_pc", bus.out_pc, 32'h40);
      end
    end
    chk("t3_seen", 32'(seen), 32'd1);

    // Back-to-back redirects: last wins
    cyc(0, 1, 32'h80, 1);
    cyc(0, 1, 32'hC0, 1);
    chk("t4_noreq", 32'(bus.imem_req), 32'd0);
    cyc(0, 0, 0, 1);
    chk("t4_addr", bus.imem_addr, 32'hC0);

    // Address wrap at the top of the space
    cyc(0, 1, 32'hFFFF_FFFE, 1);
    cyc(0, 0, 0, 1);
    chk("t5_a0", bus.imem_addr, 32'hFFFF_FFFE);
    cyc(0, 0, 0, 1);
    chk("t5_a1", bus.imem_addr, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 1);
    chk("t5_a2", bus.imem_addr, 32'h0);
    chk("t5_pc0", bus.out_pc, 32'hFFFF_FFFE);
    cyc(0, 0, 0, 1);
    chk("t5_pc1", bus.out_pc, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 1);
    chk("t5_pc2", bus.out_pc, 32'h0);

    // Reset mid-fetch drops the in-flight response
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    cyc(0, 0, 0, 1);
    chk("t6_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_addr", bus.imem_addr, 32'd0);

`ifdef FETCH_PREDECODE_EN
    cyc(0, 1, 32'h100, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t7_br", 32'(bus.out_is_branch), 32'd1);
    cyc(0, 0, 0, 1);
    chk("t7_nbr", 32'(bus.out_is_branch), 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        r;
      logic        rv;
      logic [31:0] rpc;
      r   = ($urandom_range(63) == 0);
      rv  = ($urandom_range(15) == 0);
      rpc = $urandom_range(3) == 0 ?
            32'hFFFF_FFFC + 32'($urandom_range(3)) :
            $urandom;
      cyc(r, rv, rpc, 1'($urandom_range(2) != 0));
      chk("q_bound", 32'(q_pc.size() <= DEPTH), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch front-end that sits upstream of the PC-update/branch stage. It owns the fetch PC, issues word-addressed reads to instruction memory, and buffers returned {pc, instruction} pairs in a small FIFO for the decode/execute stage. Taken branches detected downstream arrive as a redirect, which flushes the buffered and in-flight instructions and restarts fetch at the target.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
RESET_PC, 32'd0, word address fetched first after reset.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
redirect_valid  input  1  taken branch or jump from the downstream stage; flush and restart.
redirect_pc  input  32  new fetch word address; sampled when redirect_valid=1.
imem_req  output  1  read request this cycle.
imem_addr  output  32  word address of the request; equals fetch_pc.
imem_rdata  input  32  instruction data; valid exactly 1 cycle after imem_req.
out_valid  output  1  head entry available.
out_ready  input  1  consumer accepts the head entry.
out_pc  output  32  word address of the head instruction.
out_instr  output  32  head instruction.

Behaviour:
- Reset (synchronous, highest priority):
  - fetch_pc = RESET_PC; FIFO empty (count=0); inflight=0.
  - out_valid=0, imem_req=0, out_pc=0, out_instr=0.
- Credit rule: imem_req = !reset && !redirect_valid && (count + inflight < DEPTH).
  - The credit check ignores any same-cycle pop, so the FIFO never overflows.
  - imem_addr = fetch_pc (combinational).
- Issue:
  - On imem_req: fetch_pc <= fetch_pc + 1, wrapping 32'hFFFFFFFF -> 0.
  - Also inflight <= 1 and inflight_pc <= fetch_pc; otherwise inflight <= 0.
- Response:
  - When inflight=1 and no redirect this cycle, push {inflight_pc, imem_rdata} at the tail.
- Output:
  - Show-ahead FIFO: out_valid = (count != 0) && !redirect_valid.
  - out_pc/out_instr come from the head entry and hold while out_valid && !out_ready.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop leave count unchanged; either may hit an empty or full boundary legally.
- Latency: the first instruction after reset or redirect has out_valid 2 cycles after imem_req.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Redirect cycle (priority below reset, above all else):
  - FIFO cleared (count=0, pointers reset).
  - Response arriving this cycle is dropped; inflight <= 0.
  - imem_req=0; fetch_pc <= redirect_pc.
  - Any out_ready this cycle is ignored (out_valid forced 0).
- Next cycle after a redirect: request for redirect_pc; normal operation resumes.
- Back-to-back redirects: the last one wins; each flushes.
- Reset asserted mid-fetch: the in-flight response is discarded (inflight cleared by reset).
- Pointers: log2(DEPTH)-bit wrap with a separate count register (0..DEPTH).

Optional Feature:
FETCH_PREDECODE_EN
- With the macro: adds output out_is_branch (1 bit).
  - Computed at push time from imem_rdata[31:26] == 6'd18 or 6'd19, and stored per entry.
  - Reset value 0; it follows the head entry like out_instr.
- Without the macro: the port and per-entry storage are absent; all other behaviour is identical.

Decomposition:
- Shared package (upower_pkg):
  - XLEN_PC=32 and INSTR_W=32.
  - Opcode constants OP_B=6'd18 and OP_BC=6'd19.
  - typedef fetch_entry_t {pc, instr[, is_branch]}.
- One natural sub-module: fetch_fifo (parameterised show-ahead FIFO with push/pop/flush, count, full/empty).
- fetch_queue holds fetch_pc, inflight tracking and redirect control.

Test Plan:
- Reset release, memory returns instr = 32'h1000_0000 | addr, out_ready=1 -> imem_addr 0,1,2,... on consecutive cycles; out_pc=0 with out_instr=32'h10000000 two cycles after the first req; then one instruction/cycle.
- out_ready=0 for 10 cycles -> exactly DEPTH=4 requests (addr 0..3), imem_req=0 after; out_pc stays 0; on out_ready=1, entries drain 0,1,2,3 then fetch resumes at 4.
- Redirect to 32'h40 while FIFO holds 3 entries and one is in flight -> out_valid=0 in the redirect cycle; next cycle imem_addr=32'h40; first out_pc after the flush is 32'h40; no stale pc ever appears.
- Redirect on two consecutive cycles (0x80 then 0xC0) -> no request to 0x80; the next req address is 0xC0.
- fetch_pc near the top: redirect to 32'hFFFFFFFE -> requests 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0; out_pc sequence matches.
- Reset asserted the cycle after a request with out_ready=1 -> the response is dropped; out_valid=0; fetch restarts at RESET_PC.
- With FETCH_PREDECODE_EN, instr 32'h48000010 (po=18) -> out_is_branch=1; instr 32'h7C000000 -> out_is_branch=0.
